result_reporter: RTL and testbench

Completion-mailbox writer for the single-cycle RISC core. It snoops the register-file write port and keeps a shadow copy of `$v0` (register 2). When the program writes the value 1 to `$at` (register 1), it latches the `$v0` result, can halt the core, and publishes the result to the board on `OutputFPGA` and to a host reader over a valid/ack handshake. It sits beside the register file in `Main_Module`, and its 16-bit display output drives `OutputFPGA`.

---
 rtl/result_reporter.sv | 129 ++++++++++++
 tb/tb_result_reporter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/result_reporter.sv
// Completion mailbox: shadows the result register, latches it when the program writes 1 to the
// done register, and shows it on the board display. Optional core halt: RESULT_REPORTER_HALT_EN.
module result_reporter #(
    parameter int unsigned DWELL    = 50_000_000,
    parameter int unsigned DONE_REG = 1,
    parameter int unsigned RES_REG  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rf_we,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic        ack,
    output logic        halt,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [15:0] out_fpga,
    output logic        half_sel
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REPORT = 2'd1
    } state_t;

    localparam logic [4:0]  DONE_ADDR = DONE_REG[4:0];
    localparam logic [4:0]  RES_ADDR  = RES_REG[4:0];
    localparam logic [31:0] DWELL_MAX = DWELL - 1;

    state_t      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] result_q, result_d;
    logic [31:0] cnt_q, cnt_d;
    logic        half_q, half_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic [15:0] out_q, out_d;

    logic        wr_res;
    logic        wr_done;

    // Register 0 is hard-wired zero in the core, so writes to it never count.
    assign wr_res  = rf_we && (rf_waddr == RES_ADDR) && (rf_waddr != 5'd0);
    assign wr_done = rf_we && (rf_waddr == DONE_ADDR) && (rf_waddr != 5'd0)
                     && (rf_wdata == 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        half_d   = half_q;

        if (wr_res) begin
            shadow_d = rf_wdata;
        end

        case (state_q)
            ST_RUN: begin
                // Latch the pre-edge shadow; the done write cannot also be a result write.
                if (wr_done) begin
                    state_d  = ST_REPORT;
                    result_d = shadow_q;
                    cnt_d    = '0;
                    half_d   = 1'b0;
                end
            end
            ST_REPORT: begin
                if (ack) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                end else if (cnt_q == DWELL_MAX) begin
                    cnt_d  = '0;
                    half_d = ~half_q;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
                half_d  = 1'b0;
            end
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        valid_d = (state_d == ST_REPORT);
`ifdef RESULT_REPORTER_HALT_EN
        halt_d  = (state_d == ST_REPORT);
`else
        halt_d  = 1'b0;
`endif
        if (state_d == ST_REPORT) begin
            out_d = half_d ? result_d[31:16] : result_d[15:0];
        end else begin
            out_d = 16'h0000;
        end
    end

    assign halt         = halt_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign out_fpga     = out_q;
    assign half_sel     = half_q;

endmodule

// File: tb/tb_result_reporter.sv
// Directed and randomized bench for result_reporter against a cycle-count reference model.
module tb_result_reporter;

    localparam int unsigned DWELL = 4;

    logic        clk;
    logic        rst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ack;
    logic        halt;
    logic [31:0] result;
    logic        result_valid;
    logic [15:0] out_fpga;
    logic        half_sel;

    int total_cnt;
    int pass_cnt;

    // Reference model: whether a report is showing, the shadow and latched values,
    // and how many edges have elapsed since the report began.
    bit          m_report;
    logic [31:0] m_shadow;
    logic [31:0] m_result;
    int unsigned m_cycles;

    result_reporter #(.DWELL(DWELL), .DONE_REG(1), .RES_REG(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .ack          (ack),
        .halt         (halt),
        .result       (result),
        .result_valid (result_valid),
        .out_fpga     (out_fpga),
        .half_sel     (half_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        e_half;
        logic [15:0] e_out;
        logic        e_halt;
        e_half = m_report ? (((m_cycles / DWELL) % 2) == 1) : 1'b0;
        e_out  = m_report ? (e_half ? m_result[31:16] : m_result[15:0]) : 16'h0000;
`ifdef RESULT_REPORTER_HALT_EN
        e_halt = m_report;
`else
        e_halt = 1'b0;
`endif
        check("result_valid", {31'd0, result_valid}, {31'd0, m_report});
        check("halt", {31'd0, halt}, {31'd0, e_halt});
        check("result", result, m_result);
        check("out_fpga", {16'd0, out_fpga}, {16'd0, e_out});
        check("half_sel", {31'd0, half_sel}, {31'd0, e_half});
    endtask

    task automatic model_reset();
        m_report = 1'b0;
        m_shadow = '0;
        m_result = '0;
        m_cycles = 0;
    endtask

    // One clock: drive inputs, step the model on the edge, check 1 time unit later.
    task automatic cycle(input logic we, input logic [4:0] addr, input logic [31:0] data,
                         input logic a);
        rf_we    = we;
        rf_waddr = addr;
        rf_wdata = data;
        ack      = a;
        @(posedge clk);
        if (m_report) begin
            if (a) begin
                m_report = 1'b0;
                m_cycles = 0;
            end else begin
                m_cycles++;
            end
        end else if (we && addr == 5'd1 && data == 32'd1) begin
            m_report = 1'b1;
            m_result = m_shadow;
            m_cycles = 0;
        end
        if (we && addr == 5'd2) m_shadow = data;
        #1;
        check_all();
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        cycle(1'b1, addr, data, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic do_ack(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        rf_we = 1'b0;
        ack   = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        int          r;
        int          pick;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        a;

        total_cnt = 0;
        pass_cnt  = 0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        ack       = 1'b0;
        model_reset();
        rst = 1'b1;
        #12;
        check_all();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic report with half toggling every DWELL edges.
        write_reg(5'd2, 32'h0001_0037);
        write_reg(5'd1, 32'd1);
        check("basic_result", result, 32'h0001_0037);
        check("basic_low", {16'd0, out_fpga}, 32'h0000_0037);
        idle(4);
        check("basic_high", {16'd0, out_fpga}, 32'h0000_0001);
        idle(4);
        check("basic_back_low", {16'd0, out_fpga}, 32'h0000_0037);
        do_ack(1);

        // Writes that must not trigger a report.
        write_reg(5'd1, 32'd2);
        write_reg(5'd0, 32'd1);
        write_reg(5'd2, 32'd5);
        check("no_trigger_valid", {31'd0, result_valid}, 32'd0);
        write_reg(5'd1, 32'd1);
        check("trigger_result5", result, 32'd5);

        // Held ack, then re-report the unchanged shadow.
        do_ack(3);
        write_reg(5'd1, 32'd1);
        check("rereport5", result, 32'd5);

        // Writes during report update only the shadow.
        write_reg(5'd2, 32'd9);
        write_reg(5'd1, 32'd1);
        check("report_hold", result, 32'd5);
        do_ack(1);
        write_reg(5'd1, 32'd1);
        check("report9", result, 32'd9);

        // Reset mid-report, then report the cleared shadow.
        idle(2);
        async_reset();
        write_reg(5'd1, 32'd1);
        check("post_reset_result", result, 32'd0);
        check("post_reset_valid", {31'd0, result_valid}, 32'd1);
        do_ack(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                async_reset();
            end else begin
                we   = ($urandom_range(0, 3) != 0);
                pick = $urandom_range(0, 3);
                case (pick)
                    0:       addr = 5'd0;
                    1:       addr = 5'd1;
                    2:       addr = 5'd2;
                    default: addr = 5'($urandom_range(0, 31));
                endcase
                data = $urandom;
                if (addr == 5'd1 && $urandom_range(0, 1) == 1) data = 32'd1;
                a = ($urandom_range(0, 9) == 0);
                cycle(we, addr, data, a);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
